// File: rtl/pulse_sync_tx.sv
// Source-side transmitter for a strobe-qualified multi-bit CDC path: holds a word,
// raises a level strobe and completes a 4-phase handshake against a synchronized ack.
module pulse_sync_tx #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] data_out,
  output logic         stb,
  input  logic         ack_in,
  output logic         done,
  output logic         timeout_err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t         state, state_nx;
  logic [N-1:0]   data_nx;
  logic           stb_nx, done_nx, err_nx, set_err;
  logic           to_flag, to_flag_nx;
  logic [CW-1:0]  cnt, cnt_nx, cnt_inc;
  logic           ack_s1, ack_s;
  logic           wd_hit;

  assign in_ready = (state == IDLE) && ena;
  assign wd_hit   = (TIMEOUT != 0) && (cnt == TMO);
  // Saturating increment; a zero TIMEOUT pins the counter at zero.
  assign cnt_inc  = ((TIMEOUT == 0) || (cnt == TMO)) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nx   = state;
    data_nx    = data_out;
    stb_nx     = stb;
    done_nx    = 1'b0;
    set_err    = 1'b0;
    cnt_nx     = cnt;
    to_flag_nx = to_flag;
    case (state)
      IDLE: begin
        stb_nx = 1'b0;
        if (in_valid && in_ready) begin
          data_nx  = in_data;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        stb_nx     = 1'b1;
        cnt_nx     = '0;
        to_flag_nx = 1'b0;
        state_nx   = REQ;
      end
      REQ: begin
        if (ack_s) begin
          stb_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = REL;
        end else if (wd_hit) begin
          stb_nx     = 1'b0;
          set_err    = 1'b1;
          to_flag_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = REL;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      REL: begin
        stb_nx = 1'b0;
        if (!ack_s) begin
          // A transfer whose request already timed out ends silently.
          done_nx  = !to_flag;
          state_nx = IDLE;
        end else if (wd_hit) begin
          set_err  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
    err_nx = set_err | (timeout_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_out    <= '0;
      stb         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      to_flag     <= 1'b0;
      ack_s1      <= 1'b0;
      ack_s       <= 1'b0;
    end else if (ena) begin
      state       <= state_nx;
      data_out    <= data_nx;
      stb         <= stb_nx;
      done        <= done_nx;
      timeout_err <= err_nx;
      cnt         <= cnt_nx;
      to_flag     <= to_flag_nx;
      ack_s1      <= ack_in;
      ack_s       <= ack_s1;
    end
  end

endmodule

// File: tb/tb_pulse_sync_tx.sv
// Directed bench: one instance with the default watchdog for handshake/reset cases,
// one with TIMEOUT=4 for watchdog and enable-freeze cases.
module tb_pulse_sync_tx;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] m_data, m_out, w_data, w_out;
  logic       m_valid, m_ready, m_stb, m_ack, m_done, m_err, m_clr;
  logic       w_valid, w_ready, w_stb, w_ack, w_done, w_err, w_clr;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  pulse_sync_tx #(.N(8), .TIMEOUT(255), .CW(8)) u_main (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(m_data), .in_valid(m_valid),
    .in_ready(m_ready), .data_out(m_out), .stb(m_stb), .ack_in(m_ack),
    .done(m_done), .timeout_err(m_err), .err_clr(m_clr));

  pulse_sync_tx #(.N(8), .TIMEOUT(4), .CW(8)) u_wd (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(w_data), .in_valid(w_valid),
    .in_ready(w_ready), .data_out(w_out), .stb(w_stb), .ack_in(w_ack),
    .done(w_done), .timeout_err(w_err), .err_clr(w_clr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ack = 1'b0; m_clr = 1'b0;
    w_data = '0; w_valid = 1'b0; w_ack = 1'b0; w_clr = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    check("rst_data", m_out, 8'h00);
    check("rst_stb", m_stb, 1'b0);
    check("rst_done", m_done, 1'b0);
    check("rst_err", m_err, 1'b0);
    check("rst_rdy_ena0", m_ready, 1'b0);
    ena = 1'b1;
    #1;
    check("rdy_ena1", m_ready, 1'b1);

    // Single transfer A5, destination ack lags stb by 3 cycles
    m_data = 8'hA5; m_valid = 1'b1;
    tick();                               // 1: accepted
    check("t1_data", m_out, 8'hA5);
    check("t1_stb_setup", m_stb, 1'b0);
    check("t1_rdy_busy", m_ready, 1'b0);
    m_valid = 1'b0;
    tick();                               // 2: REQ
    check("t1_stb_rise", m_stb, 1'b1);
    ticks(3);                             // 5
    m_ack = 1'b1;
    ticks(2);                             // 7
    check("t1_stb_hold", m_stb, 1'b1);
    tick();                               // 8: REL
    check("t1_stb_fall", m_stb, 1'b0);
    check("t1_done_early", m_done, 1'b0);
    check("t1_data_rel", m_out, 8'hA5);
    ticks(3);                             // 11
    m_ack = 1'b0;
    ticks(2);                             // 13
    check("t1_done_pre", m_done, 1'b0);
    check("t1_rdy_pre", m_ready, 1'b0);
    tick();                               // 14: IDLE
    check("t1_done", m_done, 1'b1);
    check("t1_rdy_back", m_ready, 1'b1);

    // Back-to-back 01 then 02 with in_valid held
    m_data = 8'h01; m_valid = 1'b1;
    tick();                               // 15
    check("t1_done_clr", m_done, 1'b0);
    for (int i = 16; i <= 22; i++) begin
      tick();
      check("b2b_rdy", m_ready, 1'b0);
      check("b2b_hold", m_out, 8'h01);
      if (i == 16) m_data = 8'h02;
      if (i == 17) begin check("b2b_stb_rise", m_stb, 1'b1); m_ack = 1'b1; end
      if (i == 19) check("b2b_stb_hi", m_stb, 1'b1);
      if (i == 20) begin check("b2b_stb_fall", m_stb, 1'b0); m_ack = 1'b0; end
    end
    tick();                               // 23
    check("b2b_done1", m_done, 1'b1);
    check("b2b_data_still1", m_out, 8'h01);
    tick();                               // 24: second word accepted
    check("b2b_data2", m_out, 8'h02);
    check("b2b_done_clr", m_done, 1'b0);
    m_valid = 1'b0;
    tick();                               // 25
    check("b2b_stb2", m_stb, 1'b1);
    m_ack = 1'b1;
    ticks(3);                             // 28
    check("b2b_stb2_fall", m_stb, 1'b0);
    m_ack = 1'b0;
    ticks(3);                             // 31
    check("b2b_done2", m_done, 1'b1);
    check("b2b_err", m_err, 1'b0);

    // Watchdog in REQ, TIMEOUT=4, no ack
    w_data = 8'hC3; w_valid = 1'b1;
    tick();
    check("to_data", w_out, 8'hC3);
    w_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      tick();
      check("to_stb_hi", w_stb, 1'b1);
      check("to_err_lo", w_err, 1'b0);
    end
    tick();                               // 7: timeout
    check("to_stb_drop", w_stb, 1'b0);
    check("to_err_set", w_err, 1'b1);
    check("to_no_done_rel", w_done, 1'b0);
    tick();                               // 8: IDLE
    check("to_no_done", w_done, 1'b0);
    check("to_idle_rdy", w_ready, 1'b1);
    check("to_err_sticky", w_err, 1'b1);
    w_clr = 1'b1;
    tick();
    check("to_err_clr", w_err, 1'b0);
    w_clr = 1'b0;

    // Ack stuck high: watchdog in REL
    w_data = 8'h96; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    tick();                               // 2
    check("st_stb", w_stb, 1'b1);
    w_ack = 1'b1;
    ticks(3);                             // 5: REL
    check("st_stb_fall", w_stb, 1'b0);
    check("st_err_lo", w_err, 1'b0);
    ticks(4);                             // 9
    check("st_rel_rdy", w_ready, 1'b0);
    check("st_rel_err", w_err, 1'b0);
    tick();                               // 10
    check("st_err_set", w_err, 1'b1);
    check("st_no_done", w_done, 1'b0);
    check("st_idle_rdy", w_ready, 1'b1);
    w_ack = 1'b0; w_clr = 1'b1;
    tick();
    check("st_err_clr", w_err, 1'b0);
    check("st_no_done2", w_done, 1'b0);
    w_clr = 1'b0;
    ticks(2);

    // Enable dropped in REQ, ack rises during the gap
    w_data = 8'h5A; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    ticks(2);                             // REQ, counter 1
    ena = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("en_stb_frozen", w_stb, 1'b1);
      check("en_rdy_low", w_ready, 1'b0);
      check("en_data_hold", w_out, 8'h5A);
      if (i == 3) w_ack = 1'b1;
    end
    check("en_main_rdy_low", m_ready, 1'b0);
    ena = 1'b1;
    ticks(2);
    check("en_stb_resume", w_stb, 1'b1);
    tick();
    check("en_stb_fall", w_stb, 1'b0);
    check("en_no_to", w_err, 1'b0);
    w_ack = 1'b0;
    ticks(3);
    check("en_done", w_done, 1'b1);
    check("en_no_to2", w_err, 1'b0);

    // Async reset while stb is high
    m_data = 8'h77; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    tick();
    check("rs_stb_pre", m_stb, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_stb_async", m_stb, 1'b0);
    check("rs_data_async", m_out, 8'h00);
    #1 rst_n = 1'b1;
    #1;
    check("rs_rdy", m_ready, 1'b1);
    check("rs_stb", m_stb, 1'b0);
    m_data = 8'h3C; m_valid = 1'b1;
    tick();
    check("rs_data_3c", m_out, 8'h3C);
    m_valid = 1'b0;
    tick();
    check("rs_stb_3c", m_stb, 1'b1);
    m_ack = 1'b1;
    ticks(3);
    check("rs_stb_fall_3c", m_stb, 1'b0);
    m_ack = 1'b0;
    ticks(3);
    check("rs_done_3c", m_done, 1'b1);
    check("rs_data_keep", m_out, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
